// File: rtl/simon_sequence_gen.sv
// Simon game colour-sequence source: grows a stored sequence from a free-running
// LFSR and plays it back one colour per request.
module simon_sequence_gen #(
  parameter int          MAX_LEN   = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         LW        = $clog2(MAX_LEN + 1),
  localparam int         IW        = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          seed_load,
  input  logic [15:0]   seed_in,
  input  logic          clear,
  input  logic          append,
  input  logic          rd_start,
  input  logic          rd_next,
  output logic [1:0]    color_out,
  output logic          color_valid,
  output logic          last,
  output logic [LW-1:0] length,
  output logic          full,
  output logic          busy
);

  typedef enum logic {S_IDLE = 1'b0, S_PLAY = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [LW-1:0] length_q, length_d;
  logic [IW-1:0] rd_idx_q, rd_idx_d;
  logic [1:0]    color_out_q, color_out_d;
  logic          color_valid_q, color_valid_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          mem_we_s;
  logic [1:0]    mem_q [MAX_LEN];

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  assign full        = (length_q == LW'(MAX_LEN));
  assign length      = length_q;
  assign color_out   = color_out_q;
  assign color_valid = color_valid_q;
  assign last        = last_q;
  assign busy        = busy_q;

  // Next-state, sequence bookkeeping and next registered outputs.
  always_comb begin
    if (seed_load) begin
      lfsr_d = (seed_in == 16'h0000) ? LFSR_SEED : seed_in;
    end else begin
      lfsr_d = lfsr_step(lfsr_q);
    end

    state_d  = state_q;
    length_d = length_q;
    rd_idx_d = rd_idx_q;
    mem_we_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clear) begin
          length_d = {LW{1'b0}};
        end else if (append) begin
          if (!full) begin
            mem_we_s = 1'b1;
            length_d = length_q + LW'(1);
          end else begin
            length_d = length_q;
          end
        end else if (rd_start) begin
          if (length_q != {LW{1'b0}}) begin
            rd_idx_d = {IW{1'b0}};
            state_d  = S_PLAY;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PLAY: begin
        // Length cannot change while playing, so the registered last flag is current.
        if (rd_next) begin
          if (last_q) begin
            rd_idx_d = {IW{1'b0}};
            state_d  = S_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + IW'(1);
          end
        end else begin
          rd_idx_d = rd_idx_q;
        end
      end
      default: begin
        state_d  = S_IDLE;
        rd_idx_d = {IW{1'b0}};
      end
    endcase

    if (state_d == S_PLAY) begin
      color_out_d   = mem_q[rd_idx_d];
      color_valid_d = 1'b1;
      busy_d        = 1'b1;
      last_d        = (LW'(rd_idx_d) == (length_q - LW'(1)));
    end else begin
      color_out_d   = 2'b00;
      color_valid_d = 1'b0;
      busy_d        = 1'b0;
      last_d        = 1'b0;
    end
  end

  // State, LFSR, counters and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      lfsr_q        <= LFSR_SEED;
      length_q      <= {LW{1'b0}};
      rd_idx_q      <= {IW{1'b0}};
      color_out_q   <= 2'b00;
      color_valid_q <= 1'b0;
      last_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      length_q      <= length_d;
      rd_idx_q      <= rd_idx_d;
      color_out_q   <= color_out_d;
      color_valid_q <= color_valid_d;
      last_q        <= last_d;
      busy_q        <= busy_d;
    end
  end

  // Colour storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[length_q[IW-1:0]] <= lfsr_q[1:0];
    end
  end

endmodule
